// File: rtl/key_debouncer_pkg.sv
// Shared defaults and sizing helpers for the pushbutton debouncer.
// Imported by the per-channel debouncer and the multi-key top level.
package key_debouncer_pkg;

  localparam int DEFAULT_NUM_KEYS        = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz

  // Stable-time counter width: clog2 of the debounce time, never below one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, stable-time counter,
// debounced level and one-cycle press/release strobes.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic key_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        // Input has disagreed for the full window: accept it and restart.
        stable_d  = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    level_d = ~stable_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level_o     = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer: NUM_KEYS independent channels feeding the key PIO.
// Raw pins are active-low; all outputs are active-high and fully registered.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .key_n_i        (key_n[g]),
      .key_level_o    (key_level[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a 4-cycle debounce window: each step
// queues the outputs expected after its clock edge; a negedge checker compares.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } exp_t;

  exp_t sb[$];

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Drive one cycle and queue the outputs expected right after its edge.
  task automatic cyc(input logic rst, input logic [NK-1:0] kn,
                     input logic [NK-1:0] lvl, input logic [NK-1:0] pr,
                     input logic [NK-1:0] rl);
    reset = rst;
    key_n = kn;
    sb.push_back(exp_t'{lvl: lvl, pr: pr, rl: rl});
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic rst, input logic [NK-1:0] kn, input int n,
                      input logic [NK-1:0] lvl);
    repeat (n) cyc(rst, kn, lvl, '0, '0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (key_level === e.lvl) else begin
        errors++;
        $error("FAIL key_level got %h exp %h at %0t", key_level, e.lvl, $time);
      end
      checks++;
      assert (press_pulse === e.pr) else begin
        errors++;
        $error("FAIL press_pulse got %h exp %h at %0t", press_pulse, e.pr, $time);
      end
      checks++;
      assert (release_pulse === e.rl) else begin
        errors++;
        $error("FAIL release_pulse got %h exp %h at %0t", release_pulse, e.rl, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all keys released, then 20 quiet cycles.
    hold(1'b1, 4'hF, 3, 4'h0);
    hold(1'b0, 4'hF, 20, 4'h0);

    // Key 0 press: level and press strobe on edge DC+2.
    hold(1'b0, 4'hE, DC + 1, 4'h0);
    cyc (1'b0, 4'hE, 4'h1, 4'h1, 4'h0);
    hold(1'b0, 4'hE, 3, 4'h1);

    // Key 1 bounce 0,1,0,1 in 2-cycle runs, then held low.
    hold(1'b0, 4'hC, 2, 4'h1);
    hold(1'b0, 4'hE, 2, 4'h1);
    hold(1'b0, 4'hC, 2, 4'h1);
    hold(1'b0, 4'hE, 2, 4'h1);
    hold(1'b0, 4'hC, DC + 1, 4'h1);
    cyc (1'b0, 4'hC, 4'h3, 4'h2, 4'h0);
    hold(1'b0, 4'hC, 3, 4'h3);

    // Key 2 glitch: 3 cycles low is one short of the window.
    hold(1'b0, 4'h8, DC - 1, 4'h3);
    hold(1'b0, 4'hC, 8, 4'h3);

    // Release keys 0 and 1 together.
    hold(1'b0, 4'hF, DC + 1, 4'h3);
    cyc (1'b0, 4'hF, 4'h0, 4'h0, 4'h3);
    hold(1'b0, 4'hF, 3, 4'h0);

    // All four pressed together, then all released together.
    hold(1'b0, 4'h0, DC + 1, 4'h0);
    cyc (1'b0, 4'h0, 4'hF, 4'hF, 4'h0);
    hold(1'b0, 4'h0, 3, 4'hF);
    hold(1'b0, 4'hF, DC + 1, 4'hF);
    cyc (1'b0, 4'hF, 4'h0, 4'h0, 4'hF);
    hold(1'b0, 4'hF, 3, 4'h0);

    // Key 3 held; reset mid-count discards progress, fresh press afterwards.
    hold(1'b0, 4'h7, 3, 4'h0);
    hold(1'b1, 4'h7, 2, 4'h0);
    hold(1'b0, 4'h7, DC + 1, 4'h0);
    cyc (1'b0, 4'h7, 4'h8, 4'h8, 4'h0);
    hold(1'b0, 4'h7, 3, 4'h8);

    // Reset after the key settled: outputs clear, no release strobe, re-press.
    hold(1'b1, 4'h7, 2, 4'h0);
    hold(1'b0, 4'h7, DC + 1, 4'h0);
    cyc (1'b0, 4'h7, 4'h8, 4'h8, 4'h0);
    hold(1'b0, 4'h7, 3, 4'h8);
    hold(1'b0, 4'hF, DC + 1, 4'h8);
    cyc (1'b0, 4'hF, 4'h0, 4'h0, 4'h8);
    hold(1'b0, 4'hF, 3, 4'h0);

    @(negedge clk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of independent pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, stable-input time in clk cycles (10 ms at 50 MHz); legal range 1..2^24.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  NUM_KEYS  raw asynchronous pushbutton pins, active-low (0 = pressed).
REQ-006 key_level  output  NUM_KEYS  debounced level, active-high (1 = pressed); drives the key PIO in_port.
REQ-007 press_pulse  output  NUM_KEYS  one-cycle strobe per channel on debounced press.
REQ-008 release_pulse  output  NUM_KEYS  one-cycle strobe per channel on debounced release.

Function
REQ-009 Each key_n bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each channel SHALL hold a registered stable state (active-low, matching sync2 polarity) and a counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
REQ-011 When sync2 equals stable: counter SHALL be cleared to 0 that cycle.
REQ-012 When sync2 differs from stable and counter < DEBOUNCE_CYCLES-1: counter SHALL increment by 1.
REQ-013 When sync2 differs from stable and counter == DEBOUNCE_CYCLES-1: stable SHALL take sync2 and counter SHALL clear to 0 on the same edge.
REQ-014 key_level SHALL equal the inverse of stable, registered; no combinational path from key_n to any output.
REQ-015 press_pulse[i] SHALL be 1 for exactly the single cycle after stable[i] goes 1->0; release_pulse[i] likewise for 0->1; never both in one cycle.
REQ-016 Latency: a key_n change held steady SHALL change key_level on clock edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new value as edge 1; pulses assert in the same cycle as key_level changes.
REQ-017 Any mismatch shorter than DEBOUNCE_CYCLES consecutive cycles (bounce, glitch) SHALL produce no key_level change and no pulse.
REQ-018 Return to matching value mid-count SHALL restart the count from 0 on the next mismatch; there is no partial credit.
REQ-019 Counter SHALL never wrap; it is bounded by REQ-013.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL yield simultaneous, independent pulses.
REQ-021 DEBOUNCE_CYCLES == 1 SHALL update stable on the first mismatching cycle (latency 3 edges).

Reset
REQ-022 While reset is high: sync1, sync2, stable SHALL be all-ones (released); counters 0; key_level, press_pulse, release_pulse 0.
REQ-023 Reset asserted mid-count SHALL discard the count; a key held pressed through reset deassertion SHALL be reported as a fresh press after full latency per REQ-016.

Structure
REQ-024 Shared package SHALL hold default NUM_KEYS, default DEBOUNCE_CYCLES, and the counter-width function.
REQ-025 One sub-module key_debounce_channel (sync, counter, stable, pulse logic for one bit) SHALL be instantiated NUM_KEYS times via generate.

Verification (DEBOUNCE_CYCLES = 4 in bench)
REQ-026 Reset, key_n = 4'hF held -> key_level = 0, no pulses for 20 cycles.
REQ-027 key_n[0] 1->0 held -> key_level = 4'h1 on edge 6, press_pulse = 4'h1 for one cycle on edge 6.
REQ-028 key_n[1] bounce 0,1,0,1,0 each 2 cycles, then held 0 -> no change during bounce; key_level[1] rises 6 edges after final 1->0.
REQ-029 Glitch key_n[2] low for 3 cycles -> key_level and pulses unchanged.
REQ-030 key_n = 4'h0 together, later 4'hF together -> press_pulse = 4'hF one cycle, then release_pulse = 4'hF one cycle.
REQ-031 key_n[3] held 0, reset asserted for 2 cycles mid-count and after settle -> outputs 0 during reset; press_pulse[3] on edge 6 after reset release.
